// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch constants, RV32I opcodes, FSM encoding and IF/ID payload type
package fetch_stage_pkg;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [1:0] {BOOT, FETCH, BUF} fstate_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;
  function automatic ifid_t bubble(input logic [31:0] nop);
    return ifid_t'{nop, 32'h0, 32'h0, 1'b0};
  endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold enable and synchronous clear to bubble
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP = DEF_NOP_INSTR
) (
  input  logic  clk,
  input  logic  en,
  input  logic  clr,
  input  ifid_t d,
  output ifid_t q
);
  always_ff @(posedge clk)
    if (clr) q <= bubble(NOP);
    else if (en) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem handshake FSM with one-word skid buffer, feeding the IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        validD
);
  fstate_t state;
  logic [31:0] pcf, skid, skid_pc;
  logic redirect, take, clr, en, unused_tgt;
  ifid_t d, q;
  assign redirect = PCSrcE && state != BOOT;
  assign take = state == FETCH && imem_ready;
  assign imem_req = state == FETCH && !rst;
  assign imem_addr = pcf;
  assign unused_tgt = ^PCTargetE[1:0];
  // a cycle with no returned word still advances decode unless it is stalled
  assign clr = rst || redirect || flushD || (state == FETCH && !imem_ready && !stallD);
  assign en = !stallD && (take || state == BUF);
  assign d = state == BUF ? ifid_t'{skid, skid_pc, skid_pc + 32'd4, 1'b1}
                          : ifid_t'{imem_rdata, pcf, pcf + 32'd4, 1'b1};
  always_ff @(posedge clk)
    if (rst) begin
      state <= BOOT;
      pcf <= RESET_PC;
      skid <= '0;
      skid_pc <= '0;
    end else if (redirect) begin
      state <= FETCH;
      pcf <= {PCTargetE[31:2], 2'b00};
      skid <= '0;
      skid_pc <= '0;
    end else if (state == BOOT) begin
      state <= FETCH;
    end else if (state == BUF) begin
      if (!stallD) begin
        state <= FETCH;
        pcf <= skid_pc + 32'd4;
      end
    end else if (take) begin
      if (stallD) begin
        state <= BUF;
        skid <= imem_rdata;
        skid_pc <= pcf;
      end else begin
        pcf <= pcf + 32'd4;
      end
    end
  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (.clk(clk), .en(en), .clr(clr), .d(d), .q(q));
  assign instrD = q.instr;
  assign PCD = q.pc;
  assign PCPlus4D = q.pc4;
  assign validD = q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch scenarios checked by literals plus a per-cycle behavioural model
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 0, rst = 1, stallD = 0, flushD = 0, PCSrcE = 0, imem_ready = 1;
  logic [31:0] PCTargetE = 0;
  logic imem_req, validD, imem_req2, validD2;
  logic [31:0] imem_addr, imem_rdata, instrD, PCD, PCPlus4D;
  logic [31:0] imem_addr2, imem_rdata2, instrD2, PCD2, PCPlus4D2;
  int checks = 0, errors = 0;
  localparam ifid_t BUB = ifid_t'{32'h13, 32'h0, 32'h0, 1'b0};

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign imem_rdata2 = mem(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instrD(instrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .validD(validD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata2), .instrD(instrD2), .PCD(PCD2),
    .PCPlus4D(PCPlus4D2), .validD(validD2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: m_pc is the next address to fetch, held holds a word fetched while decode was stalled.
  ifid_t m_out = BUB, w;
  ifid_t held[$];
  logic [31:0] m_pc = 0;
  logic m_boot = 1, live = 0;

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("m_req", imem_req, !rst && !m_boot && held.size() == 0);
      chk("m_addr", imem_addr, m_pc);
      chk("m_instr", instrD, m_out.instr);
      chk("m_pcd", PCD, m_out.pc);
      chk("m_pc4", PCPlus4D, m_out.pc4);
      chk("m_valid", validD, m_out.valid);
    end
    if (rst) begin
      m_pc = 0; m_boot = 1; held.delete(); m_out = BUB; live = 1;
    end else if (m_boot) begin
      m_boot = 0;
      if (flushD) m_out = BUB;
    end else if (PCSrcE) begin
      m_pc = {PCTargetE[31:2], 2'b00}; held.delete(); m_out = BUB;
    end else if (held.size() != 0) begin
      if (!stallD) begin
        w = held.pop_front();
        m_pc = w.pc + 4;
        m_out = flushD ? BUB : w;
      end else if (flushD) m_out = BUB;
    end else if (imem_ready) begin
      w = ifid_t'{mem(m_pc), m_pc, m_pc + 32'd4, 1'b1};
      if (stallD) begin
        held.push_back(w);
        if (flushD) m_out = BUB;
      end else begin
        m_pc = m_pc + 4;
        m_out = flushD ? BUB : w;
      end
    end else if (flushD || !stallD) m_out = BUB;
  end

  initial begin
    tick; tick;
    chk("rst_valid", validD, 0);
    chk("rst_instr", instrD, 32'h13);
    chk("rst_pcd", PCD, 0);
    chk("rst_pc4", PCPlus4D, 0);
    chk("rst_req", imem_req, 0);
    rst = 0; #1;
    chk("boot_req", imem_req, 0);
    tick;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, 0);
    tick;
    chk("pcd0", PCD, 0);
    chk("valid0", validD, 1);
    chk("instr0", instrD, mem(0));
    chk("pc4_0", PCPlus4D, 4);
    chk("wrap_pcd", PCD2, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4D2, 0);
    tick;
    chk("pcd4", PCD, 4);
    chk("wrap_pcd_next", PCD2, 0);
    chk("addr8", imem_addr, 8);
    imem_ready = 0;
    tick;
    chk("bub1_valid", validD, 0);
    chk("bub1_instr", instrD, 32'h13);
    tick;
    chk("bub2_valid", validD, 0);
    chk("bub2_instr", instrD, 32'h13);
    imem_ready = 1;
    tick;
    chk("pcd8", PCD, 8);
    chk("valid8", validD, 1);
    stallD = 1;
    tick;
    chk("buf_req", imem_req, 0);
    chk("buf_hold", PCD, 8);
    tick; tick;
    chk("buf_req3", imem_req, 0);
    chk("buf_hold3", PCD, 8);
    stallD = 0;
    tick;
    chk("pcd12", PCD, 12);
    chk("instr12", instrD, mem(12));
    chk("addr16", imem_addr, 16);
    tick;
    chk("pcd16", PCD, 16);
    PCSrcE = 1; PCTargetE = 32'h0000_0102; stallD = 1;
    tick;
    chk("redir_valid", validD, 0);
    chk("redir_instr", instrD, 32'h13);
    chk("redir_addr", imem_addr, 32'h100);
    PCSrcE = 0; stallD = 0;
    tick;
    chk("pcd100", PCD, 32'h100);
    chk("valid100", validD, 1);
    chk("instr100", instrD, mem(32'h100));
    flushD = 1;
    tick;
    chk("flush_valid", validD, 0);
    chk("flush_addr", imem_addr, 32'h108);
    flushD = 0;
    tick;
    chk("pcd108", PCD, 32'h108);
    stallD = 1;
    tick;
    chk("buf2_req", imem_req, 0);
    rst = 1;
    tick;
    chk("rstbuf_pcd", PCD, 0);
    chk("rstbuf_valid", validD, 0);
    chk("rstbuf_instr", instrD, 32'h13);
    chk("rstbuf_pc4", PCPlus4D, 0);
    chk("rstbuf_req", imem_req, 0);
    rst = 0; stallD = 0;
    tick;
    chk("restart_addr", imem_addr, 0);
    tick;
    chk("restart_pcd", PCD, 0);
    chk("restart_valid", validD, 1);
    for (int i = 0; i < 300; i++) begin
      stallD = $urandom_range(0, 9) < 3;
      imem_ready = $urandom_range(0, 9) < 7;
      flushD = $urandom_range(0, 9) == 0;
      PCSrcE = $urandom_range(0, 19) == 0;
      PCTargetE = $urandom_range(0, 1023);
      tick;
    end
    stallD = 0; flushD = 0; PCSrcE = 0; imem_ready = 1;
    tick; tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
